instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Program sequencer directly upstream of the bit-serial datapath top.
- Holds a small loadable program memory of 3-bit instructions and presents one instruction at a time on o_instr with a one-cycle o_start pulse.
- Waits for the datapath's PC-increment pulse, then advances the program counter.
- Supports run, abort, loop/halt-at-end and a watchdog on the datapath handshake.

Parameters:
- INSTR_W, 3, instruction width; matches the datapath instruction input.
- DEPTH, 16, program memory entries.
- ADDR_W, $clog2(DEPTH), PC / memory address width.
- TIMEOUT, 64, maximum cycles in WAIT without i_pcincr before error.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_prog_we  in  1  program memory write enable.
- i_prog_addr  in  ADDR_W  program write address.
- i_prog_data  in  INSTR_W  program write data.
- i_prog_len  in  ADDR_W+1  number of valid instructions (0..DEPTH).
- i_run  in  1  start execution (level, sampled in IDLE/DONE/ERROR).
- i_loop  in  1  1 = wrap to PC 0 after last instruction, 0 = halt.
- i_abort  in  1  return to IDLE.
- i_pcincr  in  1  datapath finished current instruction (pulse).
- o_instr  out  INSTR_W  current instruction to datapath.
- o_start  out  1  one-cycle pulse: datapath begins executing o_instr.
- o_pc  out  ADDR_W  current program counter.
- o_busy  out  1  high in FETCH/ISSUE/WAIT.
- o_done  out  1  high in DONE.
- o_err  out  1  high in ERROR.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state=IDLE; pc=0; o_instr=0; o_start=0; o_busy=0; o_done=0; o_err=0; watchdog=0.
  - Memory contents are not cleared.
  - Reset mid-run discards the in-flight instruction; no further o_start.
- Effective length: len_eff = min(i_prog_len, DEPTH).
- States: IDLE, FETCH, ISSUE, WAIT, DONE, ERROR.
- IDLE/DONE/ERROR:
  - i_prog_we writes mem[i_prog_addr]=i_prog_data; writes in any other state are ignored.
  - i_run=1 with len_eff!=0: pc<=0, clear done/err, go FETCH.
  - i_run=1 with len_eff=0: ignored, state unchanged.
  - Write and run in the same cycle: the write lands, and the fetch reads the updated memory.
- FETCH: one synchronous memory read of mem[pc]; next state ISSUE.
- ISSUE:
  - o_instr<=read data, held stable until the next ISSUE.
  - o_start=1 for exactly this cycle; watchdog cleared; next state WAIT.
- WAIT:
  - i_pcincr=1 and pc==len_eff-1:
    - i_loop=1: pc<=0, go FETCH.
    - i_loop=0: go DONE.
  - i_pcincr=1 otherwise: pc<=pc+1, go FETCH.
  - No i_pcincr: watchdog increments; at watchdog==TIMEOUT-1, go ERROR.
- i_pcincr outside WAIT (including the ISSUE cycle) is ignored.
- i_abort has priority over everything except reset. From any state, next state is IDLE, pc<=0, o_start=0. o_instr keeps its last value.
- Latency:
  - i_run sampled at edge N → o_start high in cycle N+2.
  - i_pcincr sampled at edge M → next o_start in cycle M+2, with o_pc already updated.
- i_prog_len changing while busy takes effect at the next end-of-program compare. If pc already exceeds len_eff-1, execution continues until pc wraps at DEPTH-1 → 0 when i_loop=1, or goes to DONE at DEPTH-1 when i_loop=0.
- PC arithmetic is modulo DEPTH.

Decomposition:
- Shared package bs_pkg holds:
  - the state enum fetch_state_t;
  - the INSTR_W constant, shared with the datapath decoder;
  - the instruction opcode encodings, for bench readability.
- One natural sub-module: prog_mem (DEPTH x INSTR_W, one synchronous write port, one synchronous read port, no reset).
- The FSM, PC and watchdog stay in instr_fetch.

Test Plan:
- Reset then load mem[0..3]={3'b001,3'b010,3'b100,3'b111}, len=4, loop=0, i_run pulse; bench answers each o_start with i_pcincr 5 cycles later → o_start 4 times, o_instr sequence 1,2,4,7, o_pc 0..3, then o_done=1, o_busy=0.
- Same program with loop=1 → after the 4th i_pcincr, o_pc=0 and o_instr=1 two cycles later; 8 o_start pulses are seen in 8 handshakes.
- len=0 with i_run=1 → stays IDLE, no o_start. len=20 (>DEPTH=16) → wraps/halts after pc=15.
- Datapath never answers → o_err=1 exactly TIMEOUT cycles after entering WAIT. A new i_run then restarts at pc=0.
- i_abort during WAIT at pc=2, then i_pcincr → i_pcincr ignored; state IDLE, o_pc=0, no o_start. A write during busy to mem[1] is ignored, checked by rerunning.
- i_rst_n=0 for one cycle mid-WAIT → all outputs at reset values next cycle; memory still holds the program, and a rerun produces the same sequence.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial datapath and its instruction sequencer.
// Holds the fetch FSM states, the instruction width and the opcode encodings.
package bs_pkg;

    localparam int INSTR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } fetch_state_t;

    localparam logic [INSTR_W-1:0] OP_NOP   = 3'b000;
    localparam logic [INSTR_W-1:0] OP_LOAD  = 3'b001;
    localparam logic [INSTR_W-1:0] OP_ADD   = 3'b010;
    localparam logic [INSTR_W-1:0] OP_SUB   = 3'b011;
    localparam logic [INSTR_W-1:0] OP_SHL   = 3'b100;
    localparam logic [INSTR_W-1:0] OP_AND   = 3'b101;
    localparam logic [INSTR_W-1:0] OP_OR    = 3'b110;
    localparam logic [INSTR_W-1:0] OP_STORE = 3'b111;

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: one synchronous write port, one synchronous read port.
// Contents are deliberately not reset so a program survives a sequencer reset.
module prog_mem #(
    parameter int WIDTH  = bs_pkg::INSTR_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Program sequencer feeding the bit-serial datapath: issues one instruction at a
// time with a start pulse, waits for the datapath's PC-increment, and advances.
module instr_fetch #(
    parameter int INSTR_W = bs_pkg::INSTR_W,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_prog_we,
    input  logic [ADDR_W-1:0]  i_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_data,
    input  logic [ADDR_W:0]    i_prog_len,
    input  logic               i_run,
    input  logic               i_loop,
    input  logic               i_abort,
    input  logic               i_pcincr,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_start,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    import bs_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    fetch_state_t        state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [WD_W-1:0]     wd, wd_nxt;
    logic [INSTR_W-1:0]  instr_q;
    logic [INSTR_W-1:0]  rd_data;
    logic [ADDR_W:0]     len_eff;
    logic                idle_like;
    logic                last_pc;

    assign len_eff   = (i_prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : i_prog_len;
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);

    // A PC already past a shortened program still ends at the top of memory.
    assign last_pc = ({1'b0, pc} == (len_eff - (ADDR_W+1)'(1))) || (pc == ADDR_W'(DEPTH - 1));

    prog_mem #(
        .WIDTH  (INSTR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk     (i_clk),
        .we      (i_prog_we && idle_like),
        .wr_addr (i_prog_addr),
        .wr_data (i_prog_data),
        .rd_en   (state == ST_FETCH),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            pc      <= '0;
            wd      <= '0;
            instr_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            wd    <= wd_nxt;
            if (state == ST_ISSUE) begin
                instr_q <= rd_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wd_nxt    = wd;
        if (i_abort) begin
            state_nxt = ST_IDLE;
            pc_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_run && (len_eff != '0)) begin
                        pc_nxt    = '0;
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: state_nxt = ST_ISSUE;
                ST_ISSUE: begin
                    wd_nxt    = '0;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_pcincr) begin
                        if (last_pc && !i_loop) begin
                            state_nxt = ST_DONE;
                        end else begin
                            pc_nxt    = last_pc ? '0 : pc + ADDR_W'(1);
                            state_nxt = ST_FETCH;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        wd_nxt = wd + WD_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // The fresh read data is shown during the start cycle, then held in instr_q.
    assign o_instr = (state == ST_ISSUE) ? rd_data : instr_q;
    assign o_start = (state == ST_ISSUE) && !i_abort;
    assign o_pc    = pc;
    assign o_busy  = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT);
    assign o_done  = (state == ST_DONE);
    assign o_err   = (state == ST_ERROR);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with randomized program
// contents, lengths and handshake delays, checked against a simple array model.
module tb_instr_fetch;
    import bs_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int TIMEOUT = 64;

    localparam int STOP_NONE  = 0;
    localparam int STOP_ABORT = 1;
    localparam int STOP_RESET = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [ADDR_W:0]    prog_len;
    logic               run;
    logic               loop_en;
    logic               abort;
    logic               pcincr;
    logic [INSTR_W-1:0] o_instr;
    logic               o_start;
    logic [ADDR_W-1:0]  o_pc;
    logic               o_busy;
    logic               o_done;
    logic               o_err;

    int assert_count = 0;
    int fail_count   = 0;
    int start_count  = 0;

    logic [INSTR_W-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    instr_fetch #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_prog_len  (prog_len),
        .i_run       (run),
        .i_loop      (loop_en),
        .i_abort     (abort),
        .i_pcincr    (pcincr),
        .o_instr     (o_instr),
        .o_start     (o_start),
        .o_pc        (o_pc),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always @(negedge clk) begin
        if (o_start === 1'b1) start_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle pulse of the control inputs, sampled at the next rising edge.
    task automatic applyStimulus(input bit r, input bit a, input bit p);
        run    = r;
        abort  = a;
        pcincr = p;
        tick();
        run    = 1'b0;
        abort  = 1'b0;
        pcincr = 1'b0;
    endtask

    task automatic writeMem(input int addr, input logic [INSTR_W-1:0] data, input bit expect_land);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(addr);
        prog_data = data;
        tick();
        prog_we = 1'b0;
        if (expect_land) model_mem[addr] = data;
    endtask

    task automatic waitStart(input int budget, output int waited);
        waited = 0;
        while (o_start !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    // Runs a program and checks every issued instruction against model_mem:
    // the k-th issue must be at pc = k mod len_eff.
    task automatic runProgram(input int len, input bit lp, input int handshakes, input bit fixed_delay,
                              input int stop_at, input int stop_kind, input bit wr_with_run);
        int len_eff, hs, waited, exp_pc, d, s;
        logic [INSTR_W-1:0] v;
        len_eff  = (len > DEPTH) ? DEPTH : len;
        hs       = lp ? handshakes : len_eff;
        prog_len = (ADDR_W+1)'(len);
        loop_en  = lp;
        if (wr_with_run) begin
            v         = INSTR_W'($urandom);
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = v;
            model_mem[0] = v;
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        prog_we = 1'b0;
        waitStart(10, waited);
        checkOutput("run_latency", waited + 1, 2);
        for (int k = 0; k < hs; k++) begin
            exp_pc = k % len_eff;
            checkOutput("start_seen", o_start, 1);
            checkOutput("start_pc", o_pc, exp_pc);
            checkOutput("start_instr", o_instr, model_mem[exp_pc]);
            checkOutput("busy", o_busy, 1);
            tick();
            checkOutput("start_width", o_start, 0);
            checkOutput("instr_hold", o_instr, model_mem[exp_pc]);
            if (k == stop_at && stop_kind == STOP_ABORT) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
                checkOutput("abort_flags", {o_busy, o_done, o_err}, 0);
                checkOutput("abort_pc", o_pc, 0);
                checkOutput("abort_instr", o_instr, model_mem[exp_pc]);
                s = start_count;
                applyStimulus(1'b0, 1'b0, 1'b1);
                repeat (4) tick();
                checkOutput("abort_no_start", start_count, s);
                checkOutput("abort_pc_after", {o_busy, o_pc}, 0);
                return;
            end
            if (k == stop_at && stop_kind == STOP_RESET) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                checkOutput("reset_outputs", {o_start, o_busy, o_done, o_err, o_pc, o_instr}, 0);
                s = start_count;
                repeat (4) tick();
                checkOutput("reset_no_start", start_count, s);
                return;
            end
            if (k == 0 && stop_kind == STOP_ABORT) begin
                v = ~model_mem[1];
                writeMem(1, v, 1'b0);
            end
            d = fixed_delay ? 5 : int'($urandom_range(1, 6));
            repeat (d - 1) tick();
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (lp || k < hs - 1) begin
                waitStart(10, waited);
                checkOutput("pcincr_latency", waited + 1, 2);
            end
        end
        if (lp) begin
            checkOutput("wrap_pc", o_pc, hs % len_eff);
            checkOutput("wrap_instr", o_instr, model_mem[hs % len_eff]);
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("loop_abort_busy", o_busy, 0);
        end else begin
            checkOutput("done_flags", {o_done, o_busy, o_err}, 3'b100);
            checkOutput("done_pc", o_pc, len_eff - 1);
        end
    endtask

    initial begin
        int waited, cnt, s;
        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        run       = 1'b0;
        loop_en   = 1'b0;
        abort     = 1'b0;
        pcincr    = 1'b0;
        repeat (2) tick();
        checkOutput("reset_state", {o_start, o_busy, o_done, o_err, o_pc, o_instr}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) writeMem(i, INSTR_W'($urandom), 1'b1);
        writeMem(0, OP_LOAD, 1'b1);
        writeMem(1, OP_ADD, 1'b1);
        writeMem(2, OP_SHL, 1'b1);
        writeMem(3, OP_STORE, 1'b1);

        $display("[TB] four-instruction program, halt at end");
        runProgram(4, 1'b0, 4, 1'b1, -1, STOP_NONE, 1'b0);

        $display("[TB] zero-length run is ignored");
        s = start_count;
        prog_len = '0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("len0_no_start", start_count, s);
        checkOutput("len0_state", {o_done, o_busy}, 2'b10);

        $display("[TB] looping program, eight handshakes");
        runProgram(4, 1'b1, 8, 1'b1, -1, STOP_NONE, 1'b0);

        $display("[TB] oversize length clamps to memory depth");
        runProgram(20, 1'b0, 16, 1'b0, -1, STOP_NONE, 1'b0);
        runProgram(20, 1'b1, 18, 1'b0, -1, STOP_NONE, 1'b0);

        $display("[TB] random lengths and loop modes");
        for (int i = 0; i < 3; i++) begin
            runProgram(int'($urandom_range(1, 20)), ($urandom_range(0, 1) == 1),
                       int'($urandom_range(1, 20)), 1'b0, -1, STOP_NONE, 1'b0);
        end

        $display("[TB] watchdog on a silent datapath");
        prog_len = (ADDR_W+1)'(4);
        loop_en  = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitStart(10, waited);
        checkOutput("wd_start", o_start, 1);
        cnt = 0;
        while (o_err !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        // One edge moves ISSUE into WAIT, then TIMEOUT edges of waiting.
        checkOutput("wd_cycles", cnt, TIMEOUT + 1);
        checkOutput("wd_flags", {o_err, o_busy, o_done}, 3'b100);
        runProgram(4, 1'b0, 4, 1'b0, -1, STOP_NONE, 1'b0);

        $display("[TB] abort mid-program and write while busy");
        runProgram(4, 1'b0, 4, 1'b0, 2, STOP_ABORT, 1'b0);
        runProgram(4, 1'b0, 4, 1'b0, -1, STOP_NONE, 1'b0);

        $display("[TB] reset mid-program keeps memory");
        runProgram(4, 1'b0, 4, 1'b0, 1, STOP_RESET, 1'b0);
        runProgram(4, 1'b0, 4, 1'b0, -1, STOP_NONE, 1'b0);

        $display("[TB] write and run in the same cycle");
        runProgram(4, 1'b1, 5, 1'b0, -1, STOP_NONE, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
